// File: rtl/entropy_conditioner.sv
// Von Neumann debiaser and word packer for a raw TRNG bitstream, plus a two-tap analog smoother.
// Build with ENTROPY_COND_HEALTH_EN defined to add the repetition-count health test and FAIL state.
module entropy_conditioner #(
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned REP_LIMIT = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             raw_bit_in,
    input  logic             raw_bit_valid,
    input  logic [7:0]       analog_sample_in,
    input  logic             analog_sample_valid,
    input  logic             health_clr,
    output logic [OUT_W-1:0] entropy_word_out,
    output logic             entropy_word_valid,
    output logic [7:0]       analog_entropy_out,
    output logic             health_fail,
    output logic [4:0]       debug_bits_collected
);

    // The bit count shares the 5-bit debug port, so both parameters are capped at 31.
    if (OUT_W < 2 || OUT_W > 31 || REP_LIMIT < 2 || REP_LIMIT > 31) begin : g_bad_params
        $error("entropy_conditioner: OUT_W and REP_LIMIT must both lie in 2..31");
    end

    localparam logic [4:0] LastIdx = 5'(OUT_W - 1);

`ifdef ENTROPY_COND_HEALTH_EN
    typedef enum logic [1:0] {PairA, PairB, Fail} pair_state_e;
`else
    typedef enum logic [1:0] {PairA, PairB} pair_state_e;
`endif

    pair_state_e      state_q;
    logic             first_q;
    logic [OUT_W-1:0] acc_q;
    logic [4:0]       count_q;
    logic [OUT_W-1:0] acc_shift;
    logic             trip;

    // Pair 10 yields 1 and 01 yields 0, so the accepted bit is always the stored first bit.
    assign acc_shift            = {acc_q[OUT_W-2:0], first_q};
    assign debug_bits_collected = count_q;

`ifdef ENTROPY_COND_HEALTH_EN
    localparam logic [4:0] RepLimit = 5'(REP_LIMIT);

    logic       prev_bit_q;
    logic [4:0] run_q;
    logic [4:0] run_next;
    logic       fail_q;

    // run_q == 0 marks "no previous bit" after reset or clear; saturate once tripped.
    always_comb begin
        run_next = run_q;
        if (run_q == 5'd0 || raw_bit_in != prev_bit_q) begin
            run_next = 5'd1;
        end else if (run_q != RepLimit) begin
            run_next = run_q + 5'd1;
        end
    end

    assign trip = raw_bit_valid && !health_clr && (state_q != Fail) && (run_next == RepLimit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_bit_q <= 1'b0;
            run_q      <= 5'd0;
            fail_q     <= 1'b0;
        end else if (health_clr) begin
            run_q  <= 5'd0;
            fail_q <= 1'b0;
        end else if (raw_bit_valid) begin
            prev_bit_q <= raw_bit_in;
            run_q      <= run_next;
            if (trip) begin
                fail_q <= 1'b1;
            end
        end
    end

    assign health_fail = fail_q;
`else
    assign trip        = 1'b0;
    assign health_fail = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= PairA;
            first_q            <= 1'b0;
            acc_q              <= '0;
            count_q            <= 5'd0;
            entropy_word_out   <= '0;
            entropy_word_valid <= 1'b0;
        end else begin
            entropy_word_valid <= 1'b0;
            if (health_clr) begin
                state_q <= PairA;
                acc_q   <= '0;
                count_q <= 5'd0;
            end else if (trip) begin
`ifdef ENTROPY_COND_HEALTH_EN
                // A trip suppresses any publication the same bit would have caused.
                state_q <= Fail;
`endif
                acc_q   <= '0;
                count_q <= 5'd0;
            end else if (raw_bit_valid) begin
                unique case (state_q)
                    PairA: begin
                        first_q <= raw_bit_in;
                        state_q <= PairB;
                    end
                    PairB: begin
                        state_q <= PairA;
                        if (first_q != raw_bit_in) begin
                            if (count_q == LastIdx) begin
                                entropy_word_out   <= acc_shift;
                                entropy_word_valid <= 1'b1;
                                acc_q              <= '0;
                                count_q            <= 5'd0;
                            end else begin
                                acc_q   <= acc_shift;
                                count_q <= count_q + 5'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [7:0] prev_sample_q;
    logic [8:0] analog_sum;

    assign analog_sum = {1'b0, prev_sample_q} + {1'b0, analog_sample_in};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_sample_q      <= 8'd0;
            analog_entropy_out <= 8'd0;
        end else if (analog_sample_valid) begin
            prev_sample_q      <= analog_sample_in;
            analog_entropy_out <= analog_sum[8:1];
        end
    end

endmodule

// File: tb/tb_entropy_conditioner.sv
// Directed bench for entropy_conditioner: extraction, packing, clear, health test, analog path, reset.
module tb_entropy_conditioner;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        raw_bit_in;
    logic        raw_bit_valid;
    logic [7:0]  analog_sample_in;
    logic        analog_sample_valid;
    logic        health_clr;
    logic [15:0] entropy_word_out;
    logic        entropy_word_valid;
    logic [7:0]  analog_entropy_out;
    logic        health_fail;
    logic [4:0]  debug_bits_collected;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    entropy_conditioner #(
        .OUT_W     (16),
        .REP_LIMIT (8)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .raw_bit_in           (raw_bit_in),
        .raw_bit_valid        (raw_bit_valid),
        .analog_sample_in     (analog_sample_in),
        .analog_sample_valid  (analog_sample_valid),
        .health_clr           (health_clr),
        .entropy_word_out     (entropy_word_out),
        .entropy_word_valid   (entropy_word_valid),
        .analog_entropy_out   (analog_entropy_out),
        .health_fail          (health_fail),
        .debug_bits_collected (debug_bits_collected)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (entropy_word_valid === 1'b1) pulses++;
    end

    // Drives one valid bit for the next rising edge; consecutive calls give back-to-back bits.
    task automatic send_bit(input logic b);
        @(negedge clk);
        raw_bit_in    = b;
        raw_bit_valid = 1'b1;
    endtask

    task automatic send_pair(input logic a, input logic b);
        send_bit(a);
        send_bit(b);
    endtask

    task automatic idle();
        @(negedge clk);
        raw_bit_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (entropy_word_out !== 16'h0000) begin errors++; $display("FAIL reset_word got %h exp 0000", entropy_word_out); end
        checks++; if (entropy_word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", entropy_word_valid); end
        checks++; if (analog_entropy_out !== 8'h00) begin errors++; $display("FAIL reset_analog got %h exp 00", analog_entropy_out); end
        checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL reset_health got %b exp 0", health_fail); end
        checks++; if (debug_bits_collected !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", debug_bits_collected); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_all_zero();
        int p0 = pulses;
        for (int i = 0; i < 15; i++) send_pair(1'b0, 1'b1);
        send_bit(1'b0);
        idle();
        checks++; if (pulses !== p0) begin errors++; $display("FAIL zero_early_pulse got %0d exp %0d", pulses, p0); end
        checks++; if (debug_bits_collected !== 5'd15) begin errors++; $display("FAIL zero_count15 got %0d exp 15", debug_bits_collected); end
        send_bit(1'b1);
        idle();
        checks++; if (pulses !== p0 + 1) begin errors++; $display("FAIL zero_pulse got %0d exp %0d", pulses, p0 + 1); end
        checks++; if (entropy_word_out !== 16'h0000) begin errors++; $display("FAIL zero_word got %h exp 0000", entropy_word_out); end
        checks++; if (debug_bits_collected !== 5'd0) begin errors++; $display("FAIL zero_count_clr got %0d exp 0", debug_bits_collected); end
    endtask

    task automatic test_all_one();
        int p0 = pulses;
        for (int i = 0; i < 8; i++) send_pair(1'b1, 1'b0);
        idle();
        checks++; if (debug_bits_collected !== 5'd8) begin errors++; $display("FAIL one_count8 got %0d exp 8", debug_bits_collected); end
        for (int i = 0; i < 8; i++) send_pair(1'b1, 1'b0);
        idle();
        checks++; if (pulses !== p0 + 1) begin errors++; $display("FAIL one_pulse got %0d exp %0d", pulses, p0 + 1); end
        checks++; if (entropy_word_out !== 16'hFFFF) begin errors++; $display("FAIL one_word got %h exp ffff", entropy_word_out); end
    endtask

    task automatic test_discard();
        int p0 = pulses;
        logic [7:0] pat = 8'b1010_0101;
        for (int r = 0; r < 2; r++) begin
            for (int i = 7; i >= 0; i--) begin
                if (pat[i]) send_pair(1'b1, 1'b0);
                else        send_pair(1'b0, 1'b1);
                if (i % 2 == 1) send_pair(1'b0, 1'b0);
                else            send_pair(1'b1, 1'b1);
            end
        end
        idle();
        checks++; if (pulses !== p0 + 1) begin errors++; $display("FAIL discard_pulse got %0d exp %0d", pulses, p0 + 1); end
        checks++; if (entropy_word_out !== 16'hA5A5) begin errors++; $display("FAIL discard_word got %h exp a5a5", entropy_word_out); end
        checks++; if (debug_bits_collected !== 5'd0) begin errors++; $display("FAIL discard_count got %0d exp 0", debug_bits_collected); end
    endtask

`ifdef ENTROPY_COND_HEALTH_EN
    task automatic test_health();
        int p0 = pulses;
        for (int i = 0; i < 5; i++) send_pair(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        idle();
        checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL health_early got %b exp 0", health_fail); end
        checks++; if (debug_bits_collected !== 5'd5) begin errors++; $display("FAIL health_count5 got %0d exp 5", debug_bits_collected); end
        send_bit(1'b1);
        idle();
        checks++; if (health_fail !== 1'b1) begin errors++; $display("FAIL health_trip got %b exp 1", health_fail); end
        checks++; if (debug_bits_collected !== 5'd0) begin errors++; $display("FAIL health_count_clr got %0d exp 0", debug_bits_collected); end
        for (int i = 0; i < 3; i++) send_pair(1'b1, 1'b0);
        idle();
        checks++; if (debug_bits_collected !== 5'd0) begin errors++; $display("FAIL health_ignored got %0d exp 0", debug_bits_collected); end
        checks++; if (pulses !== p0) begin errors++; $display("FAIL health_no_pub got %0d exp %0d", pulses, p0); end
        // Clear with a coincident bit: the bit must be dropped, not stored as a pair start.
        @(negedge clk);
        health_clr    = 1'b1;
        raw_bit_in    = 1'b1;
        raw_bit_valid = 1'b1;
        @(negedge clk);
        health_clr    = 1'b0;
        raw_bit_valid = 1'b0;
        #1;
        checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL health_clr got %b exp 0", health_fail); end
        for (int i = 0; i < 16; i++) send_pair(1'b0, 1'b1);
        idle();
        checks++; if (pulses !== p0 + 1) begin errors++; $display("FAIL health_recover_pulse got %0d exp %0d", pulses, p0 + 1); end
        checks++; if (entropy_word_out !== 16'h0000) begin errors++; $display("FAIL health_recover_word got %h exp 0000", entropy_word_out); end
    endtask
`else
    task automatic test_health_off();
        int p0 = pulses;
        for (int i = 0; i < 20; i++) send_bit(1'b1);
        idle();
        checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL nohealth_fail got %b exp 0", health_fail); end
        checks++; if (debug_bits_collected !== 5'd0) begin errors++; $display("FAIL nohealth_count got %0d exp 0", debug_bits_collected); end
        checks++; if (pulses !== p0) begin errors++; $display("FAIL nohealth_pulse got %0d exp %0d", pulses, p0); end
    endtask
`endif

    task automatic test_clear();
        int p0 = pulses;
        for (int i = 0; i < 3; i++) send_pair(1'b1, 1'b0);
        send_bit(1'b1);
        idle();
        checks++; if (debug_bits_collected !== 5'd3) begin errors++; $display("FAIL clear_count3 got %0d exp 3", debug_bits_collected); end
        @(negedge clk);
        health_clr = 1'b1;
        @(negedge clk);
        health_clr = 1'b0;
        #1;
        checks++; if (debug_bits_collected !== 5'd0) begin errors++; $display("FAIL clear_count got %0d exp 0", debug_bits_collected); end
        for (int i = 0; i < 16; i++) send_pair(1'b1, 1'b0);
        idle();
        checks++; if (pulses !== p0 + 1) begin errors++; $display("FAIL clear_pulse got %0d exp %0d", pulses, p0 + 1); end
        checks++; if (entropy_word_out !== 16'hFFFF) begin errors++; $display("FAIL clear_word got %h exp ffff", entropy_word_out); end
    endtask

    task automatic test_analog();
        logic [7:0] samples [4] = '{8'h10, 8'h30, 8'hFF, 8'hFF};
        logic [7:0] expect_v [4] = '{8'h08, 8'h20, 8'h97, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            analog_sample_in    = samples[i];
            analog_sample_valid = 1'b1;
            @(negedge clk);
            analog_sample_valid = 1'b0;
            #1;
            checks++;
            if (analog_entropy_out !== expect_v[i]) begin
                errors++;
                $display("FAIL analog_%0d got %h exp %h", i, analog_entropy_out, expect_v[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        for (int i = 0; i < 10; i++) send_pair(1'b1, 1'b0);
        idle();
        checks++; if (debug_bits_collected !== 5'd10) begin errors++; $display("FAIL mid_count10 got %0d exp 10", debug_bits_collected); end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (entropy_word_out !== 16'h0000) begin errors++; $display("FAIL mid_word got %h exp 0000", entropy_word_out); end
        checks++; if (analog_entropy_out !== 8'h00) begin errors++; $display("FAIL mid_analog got %h exp 00", analog_entropy_out); end
        checks++; if (debug_bits_collected !== 5'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", debug_bits_collected); end
        checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL mid_health got %b exp 0", health_fail); end
        @(negedge clk);
        reset_n = 1'b1;
        p0 = pulses;
        for (int i = 0; i < 15; i++) send_pair(1'b1, 1'b0);
        idle();
        checks++; if (pulses !== p0) begin errors++; $display("FAIL mid_early_pulse got %0d exp %0d", pulses, p0); end
        checks++; if (debug_bits_collected !== 5'd15) begin errors++; $display("FAIL mid_count15 got %0d exp 15", debug_bits_collected); end
        send_pair(1'b1, 1'b0);
        idle();
        checks++; if (pulses !== p0 + 1) begin errors++; $display("FAIL mid_pulse got %0d exp %0d", pulses, p0 + 1); end
        checks++; if (entropy_word_out !== 16'hFFFF) begin errors++; $display("FAIL mid_word_fresh got %h exp ffff", entropy_word_out); end
    endtask

    initial begin
        reset_n             = 1'b0;
        raw_bit_in          = 1'b0;
        raw_bit_valid       = 1'b0;
        analog_sample_in    = 8'h00;
        analog_sample_valid = 1'b0;
        health_clr          = 1'b0;
        test_reset();
        test_all_zero();
        test_all_one();
        test_discard();
`ifdef ENTROPY_COND_HEALTH_EN
        test_health();
`else
        test_health_off();
`endif
        test_clear();
        test_analog();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
